vthernet_rx_slot_buffer: RTL and testbench

Parametrised receive frame buffer that sits between the UDP payload stream of the Vthernet receive path and the external RX SRAM. It replaces the single linear RX write pointer with a ring of SLOTS fixed-size frame slots. It commits a frame only when the frame ends cleanly, and rewinds aborted or oversize frames without consuming a slot. Committed frames are presented to the PicoRV/Wishbone side as a head-of-queue descriptor (slot index and byte length) with an interrupt pulse per frame.

---
 rtl/vthernet_rx_slot_buffer.sv | 151 +++++++++++++++
 tb/tb_vthernet_rx_slot_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vthernet_rx_slot_buffer.sv
// Receive frame buffer: ring of fixed-size SRAM slots, commits clean frames,
// rewinds aborted/oversize ones and presents a head-of-queue descriptor.
module vthernet_rx_slot_buffer #(
    parameter int SLOTS   = 4,
    parameter int SLOT_AW = 11,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    localparam int SI_W   = $clog2(SLOTS)
) (
    input  logic                    RX_CLK,
    input  logic                    rst_n,
    input  logic                    in_v,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic                    in_err,
    output logic                    mem_we,
    output logic [SI_W+SLOT_AW-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    slot_v,
    output logic [SI_W-1:0]         slot_idx,
    output logic [SLOT_AW:0]        slot_len,
    input  logic                    slot_release,
    output logic                    full,
    output logic                    rx_irq,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    localparam logic [SLOT_AW:0] SLOT_BYTES = {1'b1, {SLOT_AW{1'b0}}};
    localparam logic [SI_W:0]    OCC_FULL   = (SI_W+1)'(SLOTS);

    state_t           state;
    logic [SI_W-1:0]  wr_slot;
    logic [SI_W-1:0]  rd_slot;
    logic [SI_W-1:0]  commit_slot;
    logic [SI_W:0]    occ;
    logic [SI_W:0]    occ_eff;
    logic [SLOT_AW:0] offset;
    logic [SLOT_AW:0] commit_len;
    logic             commit_pend;
    logic [SLOT_AW:0] len [SLOTS];
    logic             release_ok;
    logic [CNT_W-1:0] drop_next;

    // A commit is one cycle in flight before occ sees it, so the full check
    // must count it or a back-to-back frame could overrun an occupied slot.
    assign occ_eff    = occ + {{SI_W{1'b0}}, commit_pend};
    assign release_ok = slot_release && (occ != '0);
    assign drop_next  = (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;

    assign slot_v   = (occ != '0);
    assign slot_idx = rd_slot;
    assign slot_len = len[rd_slot];
    assign full     = (occ == OCC_FULL);

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= '0;
            rd_slot <= '0;
            rx_irq  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                len[i] <= '0;
            end
        end else begin
            rx_irq <= commit_pend;
            if (commit_pend) begin
                len[commit_slot] <= commit_len;
            end
            if (release_ok) begin
                rd_slot <= rd_slot + 1'b1;
            end
            if (commit_pend && !release_ok) begin
                occ <= occ + 1'b1;
            end else if (!commit_pend && release_ok) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_slot     <= '0;
            offset      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            commit_pend <= 1'b0;
            commit_slot <= '0;
            commit_len  <= '0;
            drop_cnt    <= '0;
        end else begin
            mem_we      <= 1'b0;
            commit_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_v && !in_err) begin
                        if (occ_eff == OCC_FULL) begin
                            drop_cnt <= drop_next;
                            state    <= in_last ? IDLE : DISCARD;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {wr_slot, {SLOT_AW{1'b0}}};
                            mem_wdata <= in_data;
                            offset    <= (SLOT_AW+1)'(1);
                            if (in_last) begin
                                commit_pend <= 1'b1;
                                commit_slot <= wr_slot;
                                commit_len  <= (SLOT_AW+1)'(1);
                                wr_slot     <= wr_slot + 1'b1;
                            end else begin
                                state <= RECV;
                            end
                        end
                    end
                end
                RECV: begin
                    if (in_err) begin
                        drop_cnt <= drop_next;
                        state    <= IDLE;
                    end else if (in_v) begin
                        if (offset == SLOT_BYTES) begin
                            drop_cnt <= drop_next;
                            state    <= in_last ? IDLE : DISCARD;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {wr_slot, offset[SLOT_AW-1:0]};
                            mem_wdata <= in_data;
                            offset    <= offset + 1'b1;
                            if (in_last) begin
                                commit_pend <= 1'b1;
                                commit_slot <= wr_slot;
                                commit_len  <= offset + 1'b1;
                                wr_slot     <= wr_slot + 1'b1;
                                state       <= IDLE;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (in_err || (in_v && in_last)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vthernet_rx_slot_buffer.sv
// Directed bench for vthernet_rx_slot_buffer (SLOTS=4, SLOT_AW=4) with a
// small occupancy/pointer model supplying the expected values.
module tb_vthernet_rx_slot_buffer;

    logic        RX_CLK = 1'b0;
    logic        rst_n;
    logic        in_v;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_err;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        slot_v;
    logic [1:0]  slot_idx;
    logic [4:0]  slot_len;
    logic        slot_release;
    logic        full;
    logic        rx_irq;
    logic [15:0] drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] wr_m;
    logic [1:0] rd_m;
    int         occ_m;
    int         drop_m;
    int         len_m [4];

    vthernet_rx_slot_buffer #(
        .SLOTS  (4),
        .SLOT_AW(4),
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .RX_CLK      (RX_CLK),
        .rst_n       (rst_n),
        .in_v        (in_v),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_err      (in_err),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .slot_v      (slot_v),
        .slot_idx    (slot_idx),
        .slot_len    (slot_len),
        .slot_release(slot_release),
        .full        (full),
        .rx_irq      (rx_irq),
        .drop_cnt    (drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic model_reset();
        wr_m   = '0;
        rd_m   = '0;
        occ_m  = 0;
        drop_m = 0;
        for (int i = 0; i < 4; i++) len_m[i] = 0;
    endtask

    task automatic check_descriptor(input string tag);
        check_output({tag, "_slot_v"}, slot_v, occ_m != 0);
        check_output({tag, "_slot_idx"}, slot_idx, rd_m);
        check_output({tag, "_slot_len"}, slot_len, len_m[rd_m]);
        check_output({tag, "_full"}, full, occ_m == 4);
    endtask

    // err_at < 0 means no abort; otherwise in_err rides on that byte and the frame stops there.
    task automatic send_frame(input int n, input logic [7:0] base, input int err_at, input bit rel_on_commit);
        bit was_full;
        bit dropped;
        was_full = (occ_m == 4);
        dropped  = was_full || (n > 16) || (err_at >= 0);
        for (int i = 0; i < n; i++) begin
            in_v    = 1'b1;
            in_data = base + 8'(i);
            in_last = (i == n - 1);
            in_err  = (i == err_at);
            tick();
            if (!was_full && i < 16 && !(err_at >= 0 && i >= err_at)) begin
                check_output("mem_we", mem_we, 1);
                check_output("mem_addr", mem_addr, {wr_m, 4'(i)});
                check_output("mem_wdata", mem_wdata, base + 8'(i));
            end else begin
                check_output("mem_we_idle", mem_we, 0);
            end
            if (i == err_at) break;
        end
        in_v    = 1'b0;
        in_last = 1'b0;
        in_err  = 1'b0;
        if (dropped) begin
            if (drop_m < 65535) drop_m++;
            tick();
            check_output("drop_cnt", drop_cnt, drop_m);
            check_output("irq_on_drop", rx_irq, 0);
            check_descriptor("drop");
        end else begin
            check_output("irq_early", rx_irq, 0);
            check_output("slot_v_early", slot_v, occ_m != 0);
            slot_release = rel_on_commit;
            tick();
            slot_release = 1'b0;
            len_m[wr_m] = n;
            wr_m++;
            occ_m++;
            if (rel_on_commit) begin
                rd_m++;
                occ_m--;
            end
            check_output("rx_irq", rx_irq, 1);
            check_descriptor("commit");
            tick();
            check_output("irq_pulse_end", rx_irq, 0);
            check_output("drop_cnt_commit", drop_cnt, drop_m);
        end
    endtask

    task automatic apply_release(input string tag);
        slot_release = 1'b1;
        tick();
        slot_release = 1'b0;
        if (occ_m > 0) begin
            rd_m++;
            occ_m--;
        end
        check_descriptor(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_v         = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_err       = 1'b0;
        slot_release = 1'b0;
        model_reset();
        tick();
        check_output("rst_mem_we", mem_we, 0);
        check_output("rst_drop_cnt", drop_cnt, 0);
        check_output("rst_rx_irq", rx_irq, 0);
        check_descriptor("rst");
        tick();
        rst_n = 1'b1;
        tick();

        send_frame(5, 8'h11, -1, 0);
        send_frame(16, 8'h20, -1, 0);
        send_frame(17, 8'h40, -1, 0);
        send_frame(6, 8'h60, 3, 0);
        send_frame(3, 8'h70, -1, 0);
        send_frame(2, 8'h80, -1, 0);
        check_output("full_after_4", full, 1);
        send_frame(3, 8'h90, -1, 0);

        apply_release("rel_from_full");
        send_frame(4, 8'hA0, -1, 0);

        apply_release("rel_a");
        apply_release("rel_b");
        send_frame(1, 8'hB0, -1, 1);
        apply_release("rel_c");
        check_output("occ2_one_left", slot_v, 1);
        apply_release("rel_d");
        check_output("occ2_empty", slot_v, 0);
        apply_release("rel_empty");

        for (int k = 0; k < 4; k++) send_frame(1, 8'hC0 + 8'(k), -1, 0);
        in_v    = 1'b1;
        in_last = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            tick();
            if (drop_m < 65535) drop_m++;
        end
        in_v    = 1'b0;
        in_last = 1'b0;
        tick();
        check_output("drop_sat", drop_cnt, 16'hFFFF);
        send_frame(1, 8'hD0, -1, 0);

        apply_release("rel_pre_reset");
        in_v    = 1'b1;
        in_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hE0 + 8'(k);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_output("midrst_mem_we", mem_we, 0);
        check_output("midrst_mem_addr", mem_addr, 0);
        check_output("midrst_mem_wdata", mem_wdata, 0);
        check_output("midrst_drop_cnt", drop_cnt, 0);
        check_output("midrst_rx_irq", rx_irq, 0);
        model_reset();
        check_descriptor("midrst");
        in_v = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(2, 8'hF0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
